// File: rtl/iob_dma_sched.sv
// -----------------------------------------------------------------------------
// iob_dma_sched
//   Transfer scheduler sitting in front of the DMA engine. Picks one of N_REQ
//   requesters round-robin, captures its descriptor, hands it to the engine
//   with a single start pulse, then counts engine beats until the transfer
//   completes (done) or the beat stream goes quiet for too long (timeout).
//
// Ports
//   clk_i, rst_n_i   clock, synchronous active-low reset
//   cke_i            clock enable; low freezes every register (pulses stretch)
//   req_i            per-requester transfer request
//   req_addr_i       packed base addresses, slice k = requester k
//   req_len_i        packed word counts
//   req_dir_i        1 = AXIS->memory, 0 = memory->AXIS
//   req_if_i         packed AXIS interface selects
//   gnt_o            one-hot grant, held from capture until the done/err cycle
//   done_o, err_o    1-cycle completion / timeout pulse to the owner
//   busy_o           scheduler not idle
//   dma_*_o          captured descriptor presented to the engine
//   dma_start_o      1-cycle start pulse
//   dma_rdy_i        engine able to accept a new configuration
//   dma_beat_i       one pulse per word moved by the engine
//   state_dbg_o      current FSM state encoding, for observation only
//
// Engine handshake: the descriptor on dma_*_o is stable from grant until the
// next grant. dma_start_o rises in the cycle after dma_rdy_i is sampled high
// in WAIT_RDY and lasts one enabled cycle; the engine must not need rdy to
// stay high afterwards. dma_beat_i is only counted while in RUN.
// -----------------------------------------------------------------------------
module iob_dma_sched #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 32,
  parameter int IF_W      = 1,
  parameter int TIMEOUT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cke_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ*LEN_W-1:0]  req_len_i,
  input  logic [N_REQ-1:0]        req_dir_i,
  input  logic [N_REQ*IF_W-1:0]   req_if_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        done_o,
  output logic [N_REQ-1:0]        err_o,
  output logic                    busy_o,
  output logic [ADDR_W-1:0]       dma_addr_o,
  output logic [LEN_W-1:0]        dma_len_o,
  output logic                    dma_dir_o,
  output logic [IF_W-1:0]         dma_if_o,
  output logic                    dma_start_o,
  input  logic                    dma_rdy_i,
  input  logic                    dma_beat_i,
  output logic [2:0]              state_dbg_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_RUN      = 3'd2,
    S_DONE     = 3'd3,
    S_ERR      = 3'd4
  } state_e;

  state_e                 state_q,    state_d;
  logic [N_REQ-1:0]       gnt_q,      gnt_d;
  logic [N_REQ-1:0]       done_q,     done_d;
  logic [N_REQ-1:0]       err_q,      err_d;
  logic [PTR_W-1:0]       ptr_q,      ptr_d;
  logic [PTR_W-1:0]       own_q,      own_d;
  logic [ADDR_W-1:0]      addr_q,     addr_d;
  logic [LEN_W-1:0]       len_q,      len_d;
  logic                   dir_q,      dir_d;
  logic [IF_W-1:0]        if_q,       if_d;
  logic                   start_q,    start_d;
  logic [LEN_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [TIMEOUT_W-1:0]   tmo_cnt_q,  tmo_cnt_d;

  // Round-robin search: first set request at or after ptr_q, wrapping.
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Descriptor mux for the winning requester.
  logic [N_REQ-1:0]  sel_oh;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              sel_dir;
  logic [IF_W-1:0]   sel_if;

  always_comb begin
    sel_oh   = '0;
    sel_addr = '0;
    sel_len  = '0;
    sel_dir  = 1'b0;
    sel_if   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        sel_oh[k] = 1'b1;
        sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        sel_len   = req_len_i[k*LEN_W +: LEN_W];
        sel_dir   = req_dir_i[k];
        sel_if    = req_if_i[k*IF_W +: IF_W];
      end
    end
  end

  // Pointer moves past the owner so an immediate re-request loses to others.
  logic [PTR_W-1:0] own_next;
  assign own_next = (own_q == PTR_W'(N_REQ - 1)) ? '0 : own_q + PTR_W'(1);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = '0;
    ptr_d      = ptr_q;
    own_d      = own_q;
    addr_d     = addr_q;
    len_d      = len_q;
    dir_d      = dir_q;
    if_d       = if_q;
    start_d    = 1'b0;
    beat_cnt_d = beat_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d  = sel_oh;
          own_d  = win_idx;
          addr_d = sel_addr;
          len_d  = sel_len;
          dir_d  = sel_dir;
          if_d   = sel_if;
          // A zero-length descriptor completes without bothering the engine.
          state_d = (sel_len == '0) ? S_DONE : S_WAIT_RDY;
        end
      end

      S_WAIT_RDY: begin
        if (dma_rdy_i) begin
          start_d    = 1'b1;
          beat_cnt_d = '0;
          tmo_cnt_d  = '0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        // A beat always takes precedence over an expiring timeout.
        if (dma_beat_i) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          tmo_cnt_d  = '0;
          if (beat_cnt_q + LEN_W'(1) == len_q) begin
            state_d = S_DONE;
          end
        end else if (tmo_cnt_q == '1) begin
          state_d = S_ERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
        end
      end

      S_DONE: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        ptr_d   = own_next;
        state_d = S_IDLE;
      end

      S_ERR: begin
        err_d   = gnt_q;
        gnt_d   = '0;
        ptr_d   = own_next;
        state_d = S_IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      ptr_q      <= '0;
      own_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      dir_q      <= 1'b0;
      if_q       <= '0;
      start_q    <= 1'b0;
      beat_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else if (cke_i) begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      own_q      <= own_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      if_q       <= if_d;
      start_q    <= start_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_IDLE);
  assign dma_addr_o  = addr_q;
  assign dma_len_o   = len_q;
  assign dma_dir_o   = dir_q;
  assign dma_if_o    = if_q;
  assign dma_start_o = start_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_iob_dma_sched.sv
// -----------------------------------------------------------------------------
// tb_iob_dma_sched
//   Directed scenarios followed by randomized transfers for iob_dma_sched.
//   Expected behaviour comes from a transaction-level reference: a round-robin
//   pick over the request vector, the captured descriptor, and a beat /
//   quiet-cycle tally that decides between completion and timeout.
// -----------------------------------------------------------------------------
module tb_iob_dma_sched;

  localparam int N_REQ     = 4;
  localparam int PW        = 2;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 32;
  localparam int IF_W      = 1;
  localparam int TIMEOUT_W = 4;
  // Consecutive beat-less enabled RUN cycles that end a transfer in timeout.
  localparam int TMO_LIMIT = 1 << TIMEOUT_W;

  logic                    clk_i = 1'b0;
  logic                    rst_n_i;
  logic                    cke_i;
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*ADDR_W-1:0] req_addr_i;
  logic [N_REQ*LEN_W-1:0]  req_len_i;
  logic [N_REQ-1:0]        req_dir_i;
  logic [N_REQ*IF_W-1:0]   req_if_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        done_o;
  logic [N_REQ-1:0]        err_o;
  logic                    busy_o;
  logic [ADDR_W-1:0]       dma_addr_o;
  logic [LEN_W-1:0]        dma_len_o;
  logic                    dma_dir_o;
  logic [IF_W-1:0]         dma_if_o;
  logic                    dma_start_o;
  logic                    dma_rdy_i;
  logic                    dma_beat_i;
  logic [2:0]              state_dbg_o;

  logic [ADDR_W-1:0] d_addr [N_REQ];
  logic [LEN_W-1:0]  d_len  [N_REQ];
  logic              d_dir  [N_REQ];
  logic [IF_W-1:0]   d_if   [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_pack
    assign req_addr_i[k*ADDR_W +: ADDR_W] = d_addr[k];
    assign req_len_i[k*LEN_W +: LEN_W]    = d_len[k];
    assign req_dir_i[k]                   = d_dir[k];
    assign req_if_i[k*IF_W +: IF_W]       = d_if[k];
  end

  iob_dma_sched #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .IF_W(IF_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cke_i(cke_i),
    .req_i(req_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_dir_i(req_dir_i), .req_if_i(req_if_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .dma_addr_o(dma_addr_o), .dma_len_o(dma_len_o), .dma_dir_o(dma_dir_o),
    .dma_if_o(dma_if_o), .dma_start_o(dma_start_o),
    .dma_rdy_i(dma_rdy_i), .dma_beat_i(dma_beat_i),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  int               checks   = 0;
  int               failures = 0;
  logic [N_REQ-1:0] exp_q[$];
  logic [PW-1:0]    m_ptr;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   64'(gnt_o),       64'(0));
    check({tag, "_done"},  64'(done_o),      64'(0));
    check({tag, "_err"},   64'(err_o),       64'(0));
    check({tag, "_busy"},  64'(busy_o),      64'(0));
    check({tag, "_start"}, 64'(dma_start_o), 64'(0));
    check({tag, "_addr"},  64'(dma_addr_o),  64'(0));
    check({tag, "_len"},   64'(dma_len_o),   64'(0));
    check({tag, "_dir"},   64'(dma_dir_o),   64'(0));
    check({tag, "_if"},    64'(dma_if_o),    64'(0));
  endtask

  // Reference arbitration: first requester at or after p, wrapping.
  // Returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] j;
    for (int i = 0; i < N_REQ; i++) begin
      j = PW'((int'(p) + i) % N_REQ);
      if (r[j]) return {1'b1, j};
    end
    return '0;
  endfunction

  // ---------------- driver: one complete transfer ----------------
  // Call in a cycle where the scheduler is idle and req_i is already driven.
  // n_send < 0 means "send as many beats as the descriptor asks for".
  task automatic xfer(input int rdy_delay, input int n_send, input int gap_max,
                      input bit cke_noise, input bit stretch);
    logic [PW:0]       pick;
    logic [PW-1:0]     w;
    logic [N_REQ-1:0]  oh;
    logic [N_REQ-1:0]  s_req;
    logic [ADDR_W-1:0] e_addr, s_addr;
    logic [LEN_W-1:0]  e_len,  s_len;
    logic              e_dir,  s_dir;
    logic [IF_W-1:0]   e_if,   s_if;
    int                sent, idle, budget;
    bit                fin, is_err, exp_start, beat, en;

    pick = rr_pick(req_i, m_ptr);
    if (!pick[PW]) return;
    w  = pick[PW-1:0];
    oh = N_REQ'(1) << w;
    exp_q.push_back(oh);
    e_addr = d_addr[w];
    e_len  = d_len[w];
    e_dir  = d_dir[w];
    e_if   = d_if[w];
    if (n_send < 0) n_send = int'(e_len);

    tick();
    check("gnt",        64'(gnt_o),       64'(exp_q.pop_front()));
    check("gnt_busy",   64'(busy_o),      64'(1));
    check("cap_addr",   64'(dma_addr_o),  64'(e_addr));
    check("cap_len",    64'(dma_len_o),   64'(e_len));
    check("cap_dir",    64'(dma_dir_o),   64'(e_dir));
    check("cap_if",     64'(dma_if_o),    64'(e_if));
    check("gnt_start",  64'(dma_start_o), 64'(0));

    // Descriptor and request of the owner change after grant; must not matter.
    s_req  = req_i;
    s_addr = d_addr[w];
    s_len  = d_len[w];
    s_dir  = d_dir[w];
    s_if   = d_if[w];
    d_addr[w] = $urandom;
    d_len[w]  = $urandom;
    d_dir[w]  = 1'($urandom);
    d_if[w]   = IF_W'($urandom);
    req_i[w]  = 1'($urandom);

    is_err = 1'b0;
    if (e_len != '0) begin
      for (int i = 0; i < rdy_delay; i++) begin
        dma_rdy_i  = 1'b0;
        dma_beat_i = 1'($urandom);
        tick();
        check("wait_start", 64'(dma_start_o), 64'(0));
        check("wait_gnt",   64'(gnt_o),       64'(oh));
      end
      dma_rdy_i  = 1'b1;
      dma_beat_i = 1'($urandom);
      tick();
      dma_rdy_i = 1'($urandom);

      exp_start = 1'b1;
      sent = 0;
      idle = 0;
      fin = 1'b0;
      budget = 0;
      while (!fin && budget < 4000) begin
        en   = cke_noise ? ($urandom_range(0, 7) != 0) : 1'b1;
        beat = (sent < n_send) && ($urandom_range(0, gap_max) == 0);
        cke_i      = en;
        dma_beat_i = beat;
        check("run_gnt",   64'(gnt_o),       64'(oh));
        check("run_busy",  64'(busy_o),      64'(1));
        check("run_done",  64'(done_o),      64'(0));
        check("run_err",   64'(err_o),       64'(0));
        check("run_start", 64'(dma_start_o), 64'(exp_start));
        tick();
        budget++;
        if (en) begin
          exp_start = 1'b0;
          if (beat) begin
            sent++;
            idle = 0;
            if (sent == int'(e_len)) fin = 1'b1;
          end else begin
            idle++;
            if (idle == TMO_LIMIT) begin
              fin = 1'b1;
              is_err = 1'b1;
            end
          end
        end
      end
      checks++;
      assert (fin) else begin
        failures++;
        $error("FAIL run_bound observed=%0d expected=%0d", budget, 4000);
      end
    end

    // Terminal state: grant still held, no pulse yet, late beats ignored.
    cke_i      = 1'b1;
    dma_rdy_i  = 1'b0;
    dma_beat_i = 1'($urandom);
    check("fin_gnt",   64'(gnt_o),       64'(oh));
    check("fin_busy",  64'(busy_o),      64'(1));
    check("fin_done",  64'(done_o),      64'(0));
    check("fin_err",   64'(err_o),       64'(0));
    check("fin_start", 64'(dma_start_o), 64'(0));
    tick();

    d_addr[w] = s_addr;
    d_len[w]  = s_len;
    d_dir[w]  = s_dir;
    d_if[w]   = s_if;
    req_i     = s_req;
    dma_beat_i = 1'b0;

    check("pulse_done", 64'(done_o),     is_err ? 64'(0) : 64'(oh));
    check("pulse_err",  64'(err_o),      is_err ? 64'(oh) : 64'(0));
    check("pulse_gnt",  64'(gnt_o),      64'(0));
    check("pulse_busy", 64'(busy_o),     64'(0));
    check("hold_addr",  64'(dma_addr_o), 64'(e_addr));
    check("hold_len",   64'(dma_len_o),  64'(e_len));
    if (stretch) begin
      cke_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("stretch_done", 64'(done_o), is_err ? 64'(0) : 64'(oh));
        check("stretch_err",  64'(err_o),  is_err ? 64'(oh) : 64'(0));
      end
      cke_i = 1'b1;
    end
    m_ptr = PW'((int'(w) + 1) % N_REQ);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n_i    = 1'b0;
    cke_i      = 1'b1;
    req_i      = 4'hF;
    dma_rdy_i  = 1'b0;
    dma_beat_i = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      d_addr[k] = 32'hA000_0000 + 32'(k * 16);
      d_len[k]  = 32'd2;
      d_dir[k]  = 1'b0;
      d_if[k]   = '0;
    end
    m_ptr = '0;

    // Reset held two cycles with all requests up.
    tick();
    check_all_zero("rst1");
    tick();
    check_all_zero("rst2");
    rst_n_i = 1'b1;
    xfer(0, -1, 0, 1'b0, 1'b0);

    // Single transfer on requester 1.
    req_i     = 4'b0010;
    d_addr[1] = 32'h0000_1000;
    d_len[1]  = 32'd4;
    d_dir[1]  = 1'b1;
    d_if[1]   = 1'b1;
    xfer(0, -1, 0, 1'b0, 1'b1);

    // Reset in the middle of a running transfer.
    req_i     = 4'b0100;
    d_len[2]  = 32'd5;
    dma_rdy_i = 1'b1;
    tick();
    check("mr_gnt", 64'(gnt_o), 64'(4'b0100));
    tick();
    check("mr_start", 64'(dma_start_o), 64'(1));
    dma_rdy_i  = 1'b0;
    dma_beat_i = 1'b1;
    tick();
    tick();
    rst_n_i = 1'b0;
    tick();
    check_all_zero("mr_rst");
    rst_n_i = 1'b1;
    req_i   = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_done", 64'(done_o), 64'(0));
      check("mr_err",  64'(err_o),  64'(0));
      check("mr_busy", 64'(busy_o), 64'(0));
    end
    dma_beat_i = 1'b0;
    m_ptr = '0;

    // Round-robin among 0,1,3 with the set held: order 0,1,3,0,1.
    d_len[0] = 32'd1;
    d_len[1] = 32'd1;
    d_len[3] = 32'd1;
    req_i = 4'b1011;
    for (int i = 0; i < 5; i++) xfer(0, -1, 0, 1'b0, 1'b0);
    req_i = 4'b0000;
    tick();

    // Zero-length descriptor on requester 2.
    req_i    = 4'b0100;
    d_len[2] = 32'd0;
    xfer(0, -1, 0, 1'b0, 1'b0);
    req_i = 4'b0000;
    tick();

    // Timeout: 3 beats out of 8, then silence.
    req_i    = 4'b0001;
    d_len[0] = 32'd8;
    xfer(0, 3, 0, 1'b0, 1'b1);
    req_i = 4'b0000;
    tick();

    // Engine not ready for 10 cycles; beats meanwhile must be ignored.
    req_i    = 4'b1000;
    d_len[3] = 32'd3;
    xfer(10, -1, 0, 1'b0, 1'b0);
    req_i = 4'b0000;
    tick();

    // Randomized transfers with clock-enable gaps and mixed outcomes.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < N_REQ; k++) begin
        d_addr[k] = $urandom;
        d_len[k]  = LEN_W'($urandom_range(0, 6));
        d_dir[k]  = 1'($urandom);
        d_if[k]   = IF_W'($urandom);
      end
      req_i = N_REQ'($urandom_range(1, 15));
      xfer($urandom_range(0, 4), -1, $urandom_range(0, 20), 1'b1, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        req_i = 4'b0000;
        tick();
        check("idle_busy", 64'(busy_o), 64'(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
